// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA definitions: 640x480 timing set, colour codes and the lock-state
// encoding used by the sync decoder.
package vga_sync_decoder_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b100;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;
  localparam logic [2:0] COLOUR_BLUE  = 3'b001;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_EDGE = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Two-flop synchronizer with one-strobe falling/rising edge pulses, all
// advancing only on the pixel strobe.
module vga_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic fall,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (en) begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is the previous synchronized sample, used only for edge detection
  assign fall = en & s3 & ~s2;
  assign rise = en & ~s3 & s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position and lock status from a VGA HSYNC/VSYNC/RGB stream
// sampled on a pixel strobe; outputs lag the inputs by three strobes.
//
//  state      | meaning
//  SEARCH     | no timing reference, waiting for a VSYNC fall
//  ACQUIRE    | one frame start seen, checking one full frame
//  LOCKED     | a clean frame has been seen, pixels are reported valid
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       iHorizontalSync,
  input  logic       iVerticalSync,
  input  logic       iRed,
  input  logic       iGreen,
  input  logic       iBlue,
  output logic [9:0] oColumn,
  output logic [9:0] oRow,
  output logic [2:0] oPixel,
  output logic       oPixelValid,
  output logic       oLocked,
  output logic       oFrameStart,
  output logic       oError
);

  localparam logic [CNT_W-1:0] H_TOTAL_M1 = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_START    = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_END      = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_W   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_TOTAL    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_START    = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_END      = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_W   = CNT_W'(V_SYNC);

  logic h_fall, h_rise, v_fall, v_rise;
  logic [2:0] rgb_s1, rgb_s2;
  logic [CNT_W-1:0] hcount_q, vcount_q;
  logic [CNT_W-1:0] hcount_cur, vcount_cur, v_inc;
  logic h_seen, v_seen;
  logic viol;
  lock_state_t state, state_nxt;

  logic [9:0] col_nxt, row_nxt;
  logic [2:0] pix_nxt;
  logic vis, locked_nxt, valid_nxt, fs_nxt, err_nxt;

  vga_edge_sync u_hsync (
    .clk  (Clock),
    .rst  (Reset),
    .en   (Enable),
    .d    (iHorizontalSync),
    .fall (h_fall),
    .rise (h_rise)
  );

  vga_edge_sync u_vsync (
    .clk  (Clock),
    .rst  (Reset),
    .en   (Enable),
    .d    (iVerticalSync),
    .fall (v_fall),
    .rise (v_rise)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rgb_s1 <= '0;
      rgb_s2 <= '0;
    end else if (Enable) begin
      rgb_s1 <= {iRed, iGreen, iBlue};
      rgb_s2 <= rgb_s1;
    end
  end

  // Position of the sample currently at the second pipeline stage
  always_comb begin
    hcount_cur = h_fall ? '0 : sat_inc(hcount_q);
    v_inc      = h_fall ? sat_inc(vcount_q) : vcount_q;
    vcount_cur = v_fall ? '0 : v_inc;
  end

  always_comb begin
    viol = 1'b0;
    if (h_fall && h_seen && (hcount_q != H_TOTAL_M1))   viol = 1'b1;
    if (!h_fall && (hcount_q == CNT_EDGE))              viol = 1'b1;
    if (h_rise && h_seen && (hcount_cur != H_SYNC_W))   viol = 1'b1;
    if (v_fall && v_seen && (v_inc != V_TOTAL))         viol = 1'b1;
    if (v_rise && v_seen && (vcount_cur != V_SYNC_W))   viol = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      h_seen   <= 1'b0;
      v_seen   <= 1'b0;
    end else if (Enable) begin
      hcount_q <= hcount_cur;
      vcount_q <= vcount_cur;
      h_seen   <= h_seen | h_fall;
      v_seen   <= v_seen | v_fall;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)       state <= ST_SEARCH;
    else if (Enable) state <= state_nxt;
  end

  // A violation always beats a simultaneous frame start
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SEARCH:  if (v_fall && !viol) state_nxt = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (viol)        state_nxt = ST_SEARCH;
        else if (v_fall) state_nxt = ST_LOCKED;
      end
      ST_LOCKED:  if (viol) state_nxt = ST_SEARCH;
      default:    state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    vis = (hcount_cur >= H_START) && (hcount_cur < H_END) &&
          (vcount_cur >= V_START) && (vcount_cur < V_END);
    col_nxt    = vis ? hcount_cur - H_START : '0;
    row_nxt    = vis ? vcount_cur - V_START : '0;
    pix_nxt    = vis ? rgb_s2 : '0;
    locked_nxt = (state_nxt == ST_LOCKED);
    valid_nxt  = vis && locked_nxt;
    fs_nxt     = valid_nxt && (col_nxt == '0) && (row_nxt == '0);
    err_nxt    = viol && (state != ST_SEARCH);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oColumn     <= '0;
      oRow        <= '0;
      oPixel      <= '0;
      oPixelValid <= 1'b0;
      oLocked     <= 1'b0;
      oFrameStart <= 1'b0;
      oError      <= 1'b0;
    end else if (Enable) begin
      oColumn     <= col_nxt;
      oRow        <= row_nxt;
      oPixel      <= pix_nxt;
      oPixelValid <= valid_nxt;
      oLocked     <= locked_nxt;
      oFrameStart <= fs_nxt;
      oError      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced timing set: a timestamp
// based reference model predicts every strobe's outputs, a monitor compares.
module tb_vga_sync_decoder;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic [2:0] pix;
    logic       pv;
    logic       lk;
    logic       fs;
    logic       er;
  } obs_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] c;
  } in_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic [2:0] rgb_in = 3'b000;
  logic [9:0] col, row;
  logic [2:0] pix;
  logic       pv, lk, fs, er;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .Enable          (en),
    .iHorizontalSync (hs_in),
    .iVerticalSync   (vs_in),
    .iRed            (rgb_in[2]),
    .iGreen          (rgb_in[1]),
    .iBlue           (rgb_in[0]),
    .oColumn         (col),
    .oRow            (row),
    .oPixel          (pix),
    .oPixelValid     (pv),
    .oLocked         (lk),
    .oFrameStart     (fs),
    .oError          (er)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_pv = 0, cnt_fs = 0, cnt_er = 0;
  int en_mode = 0;
  obs_t exp_q[$];
  in_t  in_q[$];
  obs_t last_exp = '0;

  // Reference model: event timestamps counted in strobes and line starts
  int m_t, m_tline, m_L, m_Lf, m_state;
  bit m_hline, m_hframe, m_phs, m_pvs;

  function automatic int cap(input int x);
    return (x > 1023) ? 1023 : x;
  endfunction

  function automatic void model_reset();
    m_t = 0; m_tline = -1; m_L = 0; m_Lf = 0; m_state = 0;
    m_hline = 0; m_hframe = 0; m_phs = 0; m_pvs = 0;
    in_q.delete();
    in_q.push_back('0);
    in_q.push_back('0);
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit h, input bit v, input logic [2:0] c);
    in_t cur;
    bit ls, fsr, hr, vr, viol, vis;
    int hc, vc, prev;
    obs_t e;
    in_q.push_back({h, v, c});
    cur = in_q.pop_front();
    ls = m_phs && !cur.hs;
    fsr = m_pvs && !cur.vs;
    hr = !m_phs && cur.hs;
    vr = !m_pvs && cur.vs;
    viol = 0;
    if (ls) begin
      if (m_hline && (m_t - m_tline) != HT) viol = 1;
      m_tline = m_t;
      m_hline = 1;
      m_L++;
    end
    hc = m_t - m_tline;
    if (hc == 1023) viol = 1;
    hc = cap(hc);
    if (fsr) begin
      if (m_hframe && cap(m_L - m_Lf) != VT) viol = 1;
      m_Lf = m_L;
      m_hframe = 1;
    end
    vc = cap(m_L - m_Lf);
    if (hr && m_hline && hc != HS) viol = 1;
    if (vr && m_hframe && vc != VS) viol = 1;
    prev = m_state;
    if (viol) m_state = 0;
    else if (fsr) m_state = (m_state == 0) ? 1 : 2;
    vis = (hc >= HST) && (hc < HST + HV) && (vc >= VST) && (vc < VST + VV);
    e.col = vis ? 10'(hc - HST) : 10'd0;
    e.row = vis ? 10'(vc - VST) : 10'd0;
    e.pix = vis ? cur.c : 3'd0;
    e.lk  = (m_state == 2);
    e.pv  = vis && e.lk;
    e.fs  = e.pv && (e.col == 0) && (e.row == 0);
    e.er  = viol && (prev != 0);
    exp_q.push_back(e);
    m_phs = cur.hs;
    m_pvs = cur.vs;
    m_t++;
  endfunction

  task automatic check_obs(input string nm, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s t=%0t got col=%0d row=%0d pix=%b pv=%b lk=%b fs=%b er=%b required col=%0d row=%0d pix=%b pv=%b lk=%b fs=%b er=%b",
                 nm, $time, got.col, got.row, got.pix, got.pv, got.lk, got.fs, got.er,
                 want.col, want.row, want.pix, want.pv, want.lk, want.fs, want.er);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", nm, got, want);
    end
  endtask

  obs_t got_m, exp_m;
  bit   rst_s, en_s;
  always @(posedge clk) begin
    rst_s = rst;
    en_s  = en;
    #1;
    got_m = {col, row, pix, pv, lk, fs, er};
    if (rst_s) begin
      check_obs("reset", got_m, '0);
      last_exp = '0;
    end else if (en_s) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty t=%0t got a strobe output with no expectation, required one queued", $time);
      end else begin
        exp_m = exp_q.pop_front();
        check_obs("strobe", got_m, exp_m);
        last_exp = exp_m;
        if (got_m.pv) cnt_pv++;
        if (got_m.fs) cnt_fs++;
        if (got_m.er) cnt_er++;
      end
    end else begin
      check_obs("hold", got_m, last_exp);
    end
  end

  task automatic tick(input bit e, input bit h, input bit v, input logic [2:0] c);
    @(negedge clk);
    en = e; hs_in = h; vs_in = v; rgb_in = c;
    if (e && !rst) model_step(h, v, c);
  endtask

  task automatic pix_strobe(input bit h, input bit v, input logic [2:0] c);
    if (en_mode == 2)
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
    tick(1'b1, h, v, c);
    if (en_mode == 1) tick(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
  endtask

  // pat 0: red, 1: column[2:0], 2: random everywhere
  task automatic frame(input int pat, input int long_line, input int stop_line);
    for (int v = 0; v < VT; v++) begin
      int len;
      if (v == stop_line) break;
      len = (v == long_line) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        bit hb, vb, visb;
        logic [2:0] c;
        hb = (h >= HS);
        vb = (v >= VS);
        visb = (h >= HST) && (h < HST + HV) && (v >= VST) && (v < VST + VV);
        c = 3'b000;
        if (pat == 2) c = 3'($urandom);
        else if (visb) c = (pat == 0) ? 3'b100 : 3'(h - HST);
        pix_strobe(hb, vb, c);
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cnt();
    cnt_pv = 0; cnt_fs = 0; cnt_er = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; en = 1'($urandom);
    model_reset();
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at t=%0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // clean red stream: first fall after reset is hidden by the zeroed pipeline
    en_mode = 0;
    frame(0, -1, -1);
    frame(0, -1, -1);
    clear_cnt();
    frame(0, -1, -1);
    settle();
    check_int("a_locked", int'(lk), 1);
    check_int("a_valid_pixels", cnt_pv, HV * VV);
    check_int("a_frame_starts", cnt_fs, 1);
    check_int("a_errors", cnt_er, 0);

    // one lengthened line
    clear_cnt();
    frame(2, 5, -1);
    settle();
    check_int("b_error_pulses", cnt_er, 1);
    check_int("b_unlocked", int'(lk), 0);
    frame(2, -1, -1);
    settle();
    check_int("b_acquiring", int'(lk), 0);
    clear_cnt();
    frame(2, -1, -1);
    settle();
    check_int("b_relocked", int'(lk), 1);
    check_int("b_valid_pixels", cnt_pv, HV * VV);

    // enable toggling with a column pattern
    en_mode = 1;
    clear_cnt();
    frame(1, -1, -1);
    settle();
    check_int("c_frame_starts", cnt_fs, 1);
    check_int("c_valid_pixels", cnt_pv, HV * VV);
    check_int("c_locked", int'(lk), 1);

    // HSYNC stuck high until the horizontal counter saturates
    en_mode = 0;
    clear_cnt();
    repeat (1100) pix_strobe(1'b1, 1'b1, 3'($urandom));
    settle();
    check_int("d_error_pulses", cnt_er, 1);
    check_int("d_unlocked", int'(lk), 0);
    frame(0, -1, -1);
    frame(0, -1, -1);
    settle();
    check_int("d_not_yet_locked", int'(lk), 0);
    frame(0, -1, -1);
    settle();
    check_int("d_relocked", int'(lk), 1);

    // reset in the middle of the visible area, random enable gaps
    en_mode = 2;
    frame(2, -1, 6);
    do_reset(2);
    frame(2, -1, -1);
    frame(2, -1, -1);
    settle();
    check_int("e_after_two_frames", int'(lk), 0);
    frame(2, -1, -1);
    settle();
    check_int("e_relocked", int'(lk), 1);

    clear_cnt();
    frame(2, -1, -1);
    frame(2, -1, -1);
    settle();
    check_int("f_errors", cnt_er, 0);
    check_int("f_frame_starts", cnt_fs, 2);
    check_int("f_locked", int'(lk), 1);

    tick(1'b0, 1'b1, 1'b1, 3'b000);
    settle();
    check_int("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch/sync widths in pixel strobes (line total 800).
REQ-003 Parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines (frame total 525).
REQ-004 Clock  input  1  system clock; one clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  pixel strobe; every register except reset handling advances only when Enable=1.
REQ-007 iHorizontalSync  input  1  HSYNC, active-low.
REQ-008 iVerticalSync  input  1  VSYNC, active-low.
REQ-009 iRed, iGreen, iBlue  input  1 each  pixel colour bits.
REQ-010 oColumn  output  10  column of oPixel, 0..H_VISIBLE-1.
REQ-011 oRow  output  10  row of oPixel, 0..V_VISIBLE-1.
REQ-012 oPixel  output  3  {R,G,B} of the current visible pixel, 0 outside visible area.
REQ-013 oPixelValid  output  1  high while oPixel/oColumn/oRow describe a visible pixel and oLocked=1.
REQ-014 oLocked  output  1  timing locked to the parameter set.
REQ-015 oFrameStart  output  1  one-strobe pulse with the pixel at column 0, row 0 while locked.
REQ-016 oError  output  1  one-strobe pulse on any timing violation.

Function
REQ-017 All five inputs SHALL pass through a 2-stage register pipeline; outputs SHALL be registered; input-to-output latency is exactly 3 Enable strobes.
REQ-018 Line start = HSYNC falling edge (synchronized 1->0); frame start = VSYNC falling edge.
REQ-019 10-bit horizontal counter: 0 at line start, +1 per strobe, saturates at 1023; saturation is a violation.
REQ-020 10-bit vertical counter: 0 at frame start, +1 per line start.
REQ-021 Column = hcount-(H_SYNC+H_BACK) while hcount in [144,783]; row = vcount-(V_SYNC+V_BACK) while vcount in [35,514]; visible iff both hold.
REQ-022 Checks: line period (line start to line start) SHALL equal 800; HSYNC low width SHALL equal 96; frame period SHALL equal 525 lines; VSYNC low width SHALL equal 2 lines; any mismatch is a violation.
REQ-023 FSM states SEARCH, ACQUIRE, LOCKED; SEARCH -> ACQUIRE on frame start; ACQUIRE -> LOCKED on next frame start with no violation in between; ACQUIRE or LOCKED -> SEARCH on violation.
REQ-024 oLocked=1 exactly in LOCKED; on violation oError pulses and oLocked, oPixelValid drop in the same output strobe.
REQ-025 Violation coinciding with a frame start: violation wins, state SEARCH (not ACQUIRE).
REQ-026 In SEARCH, violations SHALL NOT pulse oError.
REQ-027 Enable=0: all outputs hold; a held pulse is not repeated (pulses are qualified by Enable).

Reset
REQ-028 Reset SHALL override Enable and load: state SEARCH, counters 0, pipeline 0, oColumn 0, oRow 0, oPixel 0, oPixelValid 0, oLocked 0, oFrameStart 0, oError 0.
REQ-029 Reset mid-frame SHALL discard lock; re-lock requires a fresh frame start plus one clean frame.

Structure
REQ-030 Timing constants (640x480 set) and colour codes SHALL live in the shared definitions include also used by the VGA controller; parameters default to them.
REQ-031 One sub-module vga_edge_sync (2-flop sync + falling-edge pulse, Enable-qualified) SHALL be instanced for HSYNC and VSYNC.

Verification
REQ-032 Loopback from team VGA controller, iPixel=RED, Enable=1 -> oLocked=1 after second VSYNC fall; visible oPixel=3'b100, oPixelValid=1 for 640x480 strobes per frame.
REQ-033 Locked stream, one line lengthened to 801 -> oError one pulse, oLocked=0; relocks after next clean frame.
REQ-034 HSYNC held high 1100 strobes -> violation at hcount 1023, oError pulse.
REQ-035 Reset asserted at row 200 -> all outputs 0 next clock; oLocked=1 again only after two VSYNC falls.
REQ-036 Enable toggled 1/0 each clock, pixel value pattern column[2:0] -> oColumn/oPixel consistent, latency 3 strobes, single oFrameStart per frame.
